// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches one instruction word at a time from instruction memory, holds it in
// the instruction register while the datapath executes it, then computes the
// next PC (sequential, conditional branch or jump) and fetches again.
//
// The sequencer has three states:
//   IDLE  - parked, no request outstanding
//   FETCH - one setup cycle, then imem_req held high until imem_ack
//   EXEC  - instruction register valid until exec_done
//
// Every output comes straight from a register, so there is no combinational
// path from any input to any output.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   en             run enable, sampled at instruction boundaries
//   imem_req       instruction-memory read request
//   imem_addr      word-aligned fetch address
//   imem_ack       one-cycle pulse, imem_rdata valid
//   imem_rdata     instruction word
//   op, rs, rt, rd, func, imm16
//                  fields of the held instruction
//   instr_valid    instruction register holds an instruction under execution
//   pc             address of the held instruction
//   exec_done      one-cycle pulse, datapath has finished the instruction
//   branch_eq, branch_ne, jump, zero
//                  control flow qualifiers, used only together with exec_done
//   instr_count    number of instructions fetched since reset (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [5:0]  op,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        exec_done,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    // The low two address bits are forced to zero even for the reset value.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_reg, state_next;
    logic        req_reg, req_next;
    logic [31:0] fetch_pc_reg;
    logic [31:0] pc_reg;
    logic [31:0] ir_reg;
    logic [31:0] count_reg;

    logic        ack_take;
    logic        exec_take;
    logic        branch_taken;
    logic [31:0] pc_plus4;
    logic [31:0] branch_offset;
    logic [31:0] jump_target;
    logic [31:0] target_pc;

    // An acknowledge counts only while our own request is visible on the bus;
    // this also discards acks that belong to a fetch cut short by reset.
    assign ack_take  = (state_reg == FETCH) && req_reg && imem_ack;
    assign exec_take = (state_reg == EXEC) && exec_done;

    // -------------------------------------------------------------------------
    // Next-PC computation from the held instruction
    // -------------------------------------------------------------------------
    assign pc_plus4      = pc_reg + 32'd4;
    assign branch_offset = {{14{ir_reg[15]}}, ir_reg[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], ir_reg[25:0], 2'b00};
    assign branch_taken  = (branch_eq && zero) || (branch_ne && !zero);

    always_comb begin
        target_pc = pc_plus4;
        if (jump) begin
            target_pc = jump_target;
        end else if (branch_taken) begin
            target_pc = pc_plus4 + branch_offset;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            req_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
        end
    end

    // The request rises one cycle after FETCH is entered, which keeps
    // back-to-back fetches at least three cycles apart.
    always_comb begin
        state_next = state_reg;
        req_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // en is deliberately ignored here: a started fetch completes.
                if (ack_take) begin
                    state_next = EXEC;
                end else begin
                    req_next = 1'b1;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    state_next = en ? FETCH : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC_ALIGNED;
            pc_reg       <= RESET_PC_ALIGNED;
            ir_reg       <= 32'd0;
            count_reg    <= 32'd0;
        end else begin
            if (ack_take) begin
                ir_reg    <= imem_rdata;
                pc_reg    <= fetch_pc_reg;
                count_reg <= count_reg + 32'd1;
            end
            if (exec_take) begin
                fetch_pc_reg <= target_pc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_req    = req_reg;
    assign imem_addr   = {fetch_pc_reg[31:2], 2'b00};
    assign pc          = {pc_reg[31:2], 2'b00};
    assign instr_valid = (state_reg == EXEC);
    assign instr_count = count_reg;

    assign op    = ir_reg[31:26];
    assign rs    = ir_reg[25:21];
    assign rt    = ir_reg[20:16];
    assign rd    = ir_reg[15:11];
    assign func  = ir_reg[5:0];
    assign imm16 = ir_reg[15:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed test of instr_fetch_unit. A transaction-level model (fetch address,
// held PC, held instruction, fetch count) is advanced by the stimulus tasks and
// checked against the DUT on every falling edge; hand-computed literals pin
// the model and the DUT at the interesting points.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;
    logic        instr_valid;
    logic [31:0] pc;
    logic        exec_done;
    logic        branch_eq;
    logic        branch_ne;
    logic        jump;
    logic        zero;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    // Transaction-level model
    logic [31:0] m_fetch;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_count;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .op          (op),
        .func        (func),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm16       (imm16),
        .instr_valid (instr_valid),
        .pc          (pc),
        .exec_done   (exec_done),
        .branch_eq   (branch_eq),
        .branch_ne   (branch_ne),
        .jump        (jump),
        .zero        (zero),
        .instr_count (instr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "global time limit reached");
    end

    task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Continuous comparison against the model whenever outputs are meaningful
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (imem_addr[1:0] !== 2'b00 || pc[1:0] !== 2'b00) begin
                errors++;
                $display("FAIL align actual=%h/%h required=aligned", imem_addr, pc);
            end
            if (imem_req) begin
                checks++;
                if (imem_addr !== m_fetch) begin
                    errors++;
                    $display("FAIL mon_addr actual=%h required=%h", imem_addr, m_fetch);
                end
            end
            if (instr_valid) begin
                checks++;
                if (pc !== m_pc || instr_count !== m_count ||
                    op !== m_ir[31:26] || rs !== m_ir[25:21] || rt !== m_ir[20:16] ||
                    rd !== m_ir[15:11] || func !== m_ir[5:0] || imm16 !== m_ir[15:0]) begin
                    errors++;
                    $display("FAIL mon_exec actual=pc %h cnt %h op %h rs %h rt %h rd %h fn %h imm %h required=pc %h cnt %h ir %h",
                             pc, instr_count, op, rs, rt, rd, func, imm16, m_pc, m_count, m_ir);
                end
            end
        end
    end

    task automatic model_reset;
        m_fetch = 32'h0000_0000;
        m_pc    = 32'h0000_0000;
        m_ir    = 32'h0000_0000;
        m_count = 32'h0000_0000;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({31'd0, imem_req}, 32'd1, name);
    endtask

    // Called at a falling edge; returns at the falling edge after the ack.
    task automatic do_fetch(input logic [31:0] rdata, input int delay,
                            input logic drop_en, input logic [31:0] lit_addr);
        wait_req("req_seen");
        chk(imem_addr, lit_addr, "fetch_addr");
        for (int i = 0; i < delay; i++) begin
            if (i == 1 && drop_en) en = 1'b0;
            @(negedge clk);
            chk(imem_addr, lit_addr, "addr_stable");
            chk({31'd0, imem_req}, 32'd1, "req_hold");
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        m_pc       = m_fetch;
        m_ir       = rdata;
        m_count    = m_count + 32'd1;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk({31'd0, instr_valid}, 32'd1, "valid_after_ack");
        $display("FETCH addr=%h instr=%h count=%0d", lit_addr, rdata, m_count);
    endtask

    // Called at a falling edge in EXEC; returns at the falling edge after exec_done.
    task automatic do_exec(input logic j, input logic beq, input logic bne, input logic z,
                           input logic en_after, input logic [31:0] lit_next);
        logic [31:0] pc4;
        int          off;
        // Stray ack while executing must not disturb the held instruction.
        imem_ack   = 1'b1;
        imem_rdata = ~m_ir;
        @(negedge clk);
        imem_ack   = 1'b0;
        jump       = j;
        branch_eq  = beq;
        branch_ne  = bne;
        zero       = z;
        exec_done  = 1'b1;
        en         = en_after;
        pc4 = m_pc + 32'd4;
        off = $signed(m_ir[15:0]);
        if (j)
            m_fetch = (pc4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
        else if ((beq && z) || (bne && !z))
            m_fetch = pc4 + 32'(off * 4);
        else
            m_fetch = pc4;
        chk(m_fetch, lit_next, "model_next");
        @(negedge clk);
        exec_done = 1'b0;
        jump      = 1'b0;
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        zero      = 1'b0;
        chk({31'd0, instr_valid}, 32'd0, "valid_drop");
        $display("EXEC pc=%h j=%0b beq=%0b bne=%0b z=%0b next=%h", m_pc, j, beq, bne, z, m_fetch);
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        exec_done  = 1'b0;
        branch_eq  = 1'b0;
        branch_ne  = 1'b0;
        jump       = 1'b0;
        zero       = 1'b0;
        model_reset();
        #1;
        chk({31'd0, imem_req}, 32'd0, "rst_req");
        chk({31'd0, instr_valid}, 32'd0, "rst_valid");
        chk(pc, 32'd0, "rst_pc");
        chk(instr_count, 32'd0, "rst_count");
        chk({5'd0, op, rs, rt, rd, func}, 32'd0, "rst_fields");
        chk({16'd0, imm16}, 32'd0, "rst_imm");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // First fetch from RESET_PC
        do_fetch(32'h0000_0020, 0, 1'b0, 32'h0000_0000);
        chk({26'd0, op}, 32'd0, "first_op");
        chk({26'd0, func}, 32'h20, "first_func");
        chk(instr_count, 32'd1, "first_count");
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0004);

        do_fetch(32'h0800_0004, 0, 1'b0, 32'h0000_0004);
        do_exec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0010);
        // Sequential step from 0x10
        do_fetch(32'h0123_4567, 0, 1'b0, 32'h0000_0010);
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0014);
        do_fetch(32'h0800_0040, 0, 1'b0, 32'h0000_0014);
        do_exec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        // Branch cases at 0x100 with imm16 = 0xFFFE
        do_fetch(32'h1000_FFFE, 0, 1'b0, 32'h0000_0100);
        do_exec(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_00FC);
        do_fetch(32'h0800_0040, 0, 1'b0, 32'h0000_00FC);
        do_exec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        do_fetch(32'h1000_FFFE, 0, 1'b0, 32'h0000_0100);
        do_exec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0104);
        do_fetch(32'h0800_0040, 0, 1'b0, 32'h0000_0104);
        do_exec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        do_fetch(32'h1400_FFFE, 0, 1'b0, 32'h0000_0100);
        do_exec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00FC);
        // Climb to 0x1000_0000 then jump with branch also asserted
        do_fetch(32'h0BFF_FFFF, 0, 1'b0, 32'h0000_00FC);
        do_exec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0FFF_FFFC);
        do_fetch(32'h0000_0000, 0, 1'b0, 32'h0FFF_FFFC);
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0000);
        do_fetch(32'h0800_0040, 0, 1'b0, 32'h1000_0000);
        chk(instr_count, 32'd12, "count_12");
        do_exec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_0100);

        // Slow ack, en dropped mid-fetch, park in IDLE afterwards
        do_fetch(32'h0000_0025, 5, 1'b1, 32'h1000_0100);
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0104);
        chk({31'd0, imem_req}, 32'd0, "idle_req");
        exec_done = 1'b1;
        jump      = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        jump      = 1'b0;
        chk({31'd0, imem_req}, 32'd0, "idle_req2");
        chk({31'd0, instr_valid}, 32'd0, "idle_valid");
        @(negedge clk);
        chk({31'd0, imem_req}, 32'd0, "idle_req3");
        en = 1'b1;
        do_fetch(32'h0000_0020, 0, 1'b0, 32'h1000_0104);
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0108);

        // Reset during an outstanding fetch, stray ack after release
        wait_req("r37_req");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk({31'd0, imem_req}, 32'd0, "r37_req_drop");
        chk({31'd0, instr_valid}, 32'd0, "r37_valid");
        chk(instr_count, 32'd0, "r37_count");
        #1 rst_n = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack   = 1'b0;
        chk({31'd0, instr_valid}, 32'd0, "r37_stray_valid");
        chk(instr_count, 32'd0, "r37_stray_count");
        $display("RESET mid-fetch, stray ack ignored");

        // Backward branch from 0 wraps to 0xFFFF_FFFC, then +4 wraps to 0
        do_fetch(32'h1000_FFFE, 0, 1'b0, 32'h0000_0000);
        chk(instr_count, 32'd1, "r37_first_count");
        do_exec(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0000, 0, 1'b0, 32'hFFFF_FFFC);
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);
        do_fetch(32'h0000_0020, 0, 1'b0, 32'h0000_0000);
        chk(instr_count, 32'd3, "count_3");
        do_exec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  run enable; 0 parks the unit in IDLE at the next instruction boundary.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  32  byte address of the requested word (current PC).
REQ-007 imem_ack  input  1  one-cycle pulse: imem_rdata valid this cycle.
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 op, func  output  6 each  instr[31:26], instr[5:0] to the control unit.
REQ-010 rs, rt, rd  output  5 each  instr[25:21], [20:16], [15:11].
REQ-011 imm16  output  16  instr[15:0].
REQ-012 instr_valid  output  1  instruction register holds a valid instruction awaiting execution.
REQ-013 pc  output  32  address of the instruction in the instruction register.
REQ-014 exec_done  input  1  one-cycle pulse from the datapath: current instruction complete; branch/jump inputs valid this cycle.
REQ-015 branch_eq, branch_ne, jump, zero  input  1 each  control-unit outputs and ALU zero flag, sampled only with exec_done.
REQ-016 instr_count  output  32  number of instructions fetched since reset.

Function
REQ-017 FSM states: IDLE, FETCH, EXEC; encoded state register only, outputs derived from registers (no combinational path from inputs to outputs).
REQ-018 IDLE: imem_req=0, instr_valid=0; en=1 -> FETCH next cycle.
REQ-019 FETCH: imem_req=1, imem_addr=pc_next register, held stable until imem_ack.
REQ-020 FETCH with imem_ack=1: latch imem_rdata into instruction register, pc <= fetch address, instr_count += 1 (mod 2^32), -> EXEC.
REQ-021 en deasserted during FETCH SHALL NOT abort the fetch; it completes into EXEC.
REQ-022 imem_ack outside FETCH SHALL be ignored; exec_done outside EXEC SHALL be ignored.
REQ-023 EXEC: instr_valid=1, field outputs stable; remains until exec_done=1.
REQ-024 On exec_done, pc_plus4 = pc + 4 (mod 2^32); next PC:
  - jump=1: {pc_plus4[31:28], instr[25:0], 2'b00} (jump has priority over branches);
  - else (branch_eq & zero) | (branch_ne & ~zero): pc_plus4 + (sign_extend(imm16) << 2), mod 2^32;
  - else pc_plus4.
REQ-025 After exec_done: en=1 -> FETCH, en=0 -> IDLE; next PC retained in both cases.
REQ-026 Minimum latency: req asserted 1 cycle after entering FETCH; ack same cycle as req -> EXEC next cycle; fetch-to-fetch ≥3 cycles.
REQ-027 imem_addr[1:0] and pc[1:0] SHALL always be 2'b00.
REQ-028 PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no error.

Reset
REQ-029 rst_n=0 immediately (asynchronously): state=IDLE, imem_req=0, instr_valid=0, pc=RESET_PC, next PC=RESET_PC, instruction register=0 (all field outputs 0), instr_count=0.
REQ-030 Reset during FETCH drops imem_req immediately; a late imem_ack after reset release SHALL be ignored.
REQ-031 After rst_n rises, first fetch address SHALL be RESET_PC.

Verification
REQ-032 Reset release, en=1, ack on first req cycle with rdata=32'h0000_0020 -> imem_addr=0, op=0, func=6'h20, instr_valid=1, instr_count=1.
REQ-033 Sequential: exec_done with no branch/jump at pc=0x10 -> next imem_addr=0x14.
REQ-034 Branch: pc=0x100, imm16=16'hFFFE, branch_eq=1, zero=1 -> next fetch 0x0FC; same with zero=0 -> 0x104; branch_ne=1, zero=0 -> 0x0FC.
REQ-035 Jump+branch_eq+zero together at pc=0x1000_0000, instr[25:0]=26'h0000040 -> next fetch 0x1000_0100.
REQ-036 Ack delayed 5 cycles with en dropped mid-fetch -> imem_addr stable, fetch completes, after exec_done state IDLE, imem_req=0.
REQ-037 rst_n pulsed low during FETCH, stray ack after release -> ignored, instr_valid=0, next fetch at RESET_PC, instr_count=0.
